// File: rtl/avalon_bridge_pkg.sv
// Shared types and helpers for the Avalon-MM burst slave bridge and its credit counter.
// The write FSM encoding, burstcount normalisation and a constant-safe clog2 are kept here.
package avalon_bridge_pkg;

  typedef enum logic {
    W_IDLE = 1'b0,
    W_DATA = 1'b1
  } w_state_e;

  // Avalon allows burstcount 0 on some fabrics; the bridge treats it as a single beat.
  function automatic int unsigned effective_burst(input int unsigned burstcount);
    return (burstcount == 0) ? 1 : burstcount;
  endfunction

  function automatic int unsigned clog2(input int unsigned value);
    int unsigned r;
    r = 0;
    while ((64'd1 << r) < 64'(value)) begin
      r = r + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/avs_read_credit_counter.sv
// Tracks outstanding read beats and grants a credit only when a whole burst still fits.
// Increment on AR handshake and decrement on each returned beat net out in a single cycle.
module avs_read_credit_counter
  import avalon_bridge_pkg::*;
#(
  parameter int unsigned C_MAX_PENDING_BEATS = 16,
  parameter int unsigned C_LEN_WIDTH         = 4
) (
  input  logic                                    clk,
  input  logic                                    srst,
  input  logic [C_LEN_WIDTH-1:0]                  burst_len,
  input  logic                                    ar_fire,
  input  logic                                    rvalid,
  output logic                                    credit_ok,
  output logic [clog2(C_MAX_PENDING_BEATS+1)-1:0] pending
);

  localparam int unsigned PEND_W = clog2(C_MAX_PENDING_BEATS + 1);
  localparam int unsigned SUM_W  = ((PEND_W > C_LEN_WIDTH) ? PEND_W : C_LEN_WIDTH) + 1;

  logic [PEND_W-1:0] pending_q;
  logic [PEND_W-1:0] pending_d;
  logic [SUM_W-1:0]  demand;

  // One extra bit so pending + burst never wraps before the comparison.
  assign demand    = SUM_W'(pending_q) + SUM_W'(burst_len);
  assign credit_ok = (demand <= SUM_W'(C_MAX_PENDING_BEATS));
  assign pending   = pending_q;

  always_comb begin
    pending_d = pending_q;
    if (ar_fire) begin
      pending_d = pending_d + PEND_W'(burst_len);
    end
    // Beats returning after a reset flushed the count are forwarded upstream but not counted.
    if (rvalid && (pending_q != '0)) begin
      pending_d = pending_d - PEND_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      pending_q <= '0;
    end else begin
      pending_q <= pending_d;
    end
  end

endmodule

// File: rtl/avalon_burst_slave_interface.sv
// Avalon-MM burst slave to AW/W/AR/R user-bus bridge with a credit-limited read path.
// Writes take one address cycle then stream beats; reads issue only from idle with no write pending.
module avalon_burst_slave_interface
  import avalon_bridge_pkg::*;
#(
  parameter int unsigned C_AVS_ADDR_WIDTH    = 32,
  parameter int unsigned C_AVS_DATA_WIDTH    = 32,
  parameter int unsigned C_AVS_BURST_WIDTH   = 4,
  parameter int unsigned C_MAX_PENDING_BEATS = 16
) (
  input  logic                            ACLK,
  input  logic                            ARESET,
  output logic [C_AVS_ADDR_WIDTH-1:0]     awaddr,
  output logic [C_AVS_BURST_WIDTH-1:0]    awlen,
  output logic                            awvalid,
  input  logic                            awready,
  output logic [C_AVS_DATA_WIDTH-1:0]     wdata,
  output logic [C_AVS_DATA_WIDTH/8-1:0]   wstrb,
  output logic                            wlast,
  output logic                            wvalid,
  input  logic                            wready,
  output logic [C_AVS_ADDR_WIDTH-1:0]     araddr,
  output logic [C_AVS_BURST_WIDTH-1:0]    arlen,
  output logic                            arvalid,
  input  logic                            arready,
  input  logic [C_AVS_DATA_WIDTH-1:0]     rdata,
  input  logic                            rlast,
  input  logic                            rvalid,
  output logic                            rready,
  input  logic [C_AVS_ADDR_WIDTH-1:0]     avs_address,
  input  logic [C_AVS_BURST_WIDTH-1:0]    avs_burstcount,
  input  logic [C_AVS_DATA_WIDTH/8-1:0]   avs_byteenable,
  input  logic                            avs_read,
  input  logic                            avs_write,
  input  logic [C_AVS_DATA_WIDTH-1:0]     avs_writedata,
  output logic                            avs_waitrequest,
  output logic [C_AVS_DATA_WIDTH-1:0]     avs_readdata,
  output logic                            avs_readdatavalid
);

  localparam int unsigned BW     = C_AVS_BURST_WIDTH;
  localparam int unsigned PEND_W = clog2(C_MAX_PENDING_BEATS + 1);

  w_state_e          state_q;
  w_state_e          state_d;
  logic [BW-1:0]     beats_q;
  logic [BW-1:0]     beats_d;
  logic [BW-1:0]     eff_burst;
  logic              credit_ok;
  logic              ar_fire;
  logic [PEND_W-1:0] pending_beats;
  logic              unused_rlast;

  assign eff_burst    = BW'(effective_burst(32'(avs_burstcount)));
  assign unused_rlast = rlast;

  // Address, length and data are pure pass-throughs; only the valids and stall are state-dependent.
  assign awaddr  = avs_address;
  assign awlen   = eff_burst - BW'(1);
  assign araddr  = avs_address;
  assign arlen   = eff_burst - BW'(1);
  assign wdata   = avs_writedata;
  assign wstrb   = avs_byteenable;
  assign wlast   = (beats_q == BW'(1));
  assign ar_fire = arvalid && arready;

  assign rready            = 1'b1;
  assign avs_readdata      = rdata;
  assign avs_readdatavalid = rvalid;

  always_comb begin
    state_d         = state_q;
    beats_d         = beats_q;
    awvalid         = 1'b0;
    wvalid          = 1'b0;
    arvalid         = 1'b0;
    avs_waitrequest = 1'b1;
    if (!ARESET) begin
      case (state_q)
        W_IDLE: begin
          // Write wins if a master illegally raises read and write together.
          if (avs_write) begin
            awvalid = 1'b1;
            if (awready) begin
              beats_d = eff_burst;
              state_d = W_DATA;
            end
          end else if (avs_read && credit_ok) begin
            arvalid         = 1'b1;
            avs_waitrequest = !arready;
          end
        end
        W_DATA: begin
          wvalid          = avs_write;
          avs_waitrequest = !(avs_write && wready);
          if (avs_write && wready) begin
            beats_d = beats_q - BW'(1);
            if (beats_q == BW'(1)) begin
              state_d = W_IDLE;
            end
          end
        end
        default: state_d = W_IDLE;
      endcase
    end
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state_q <= W_IDLE;
      beats_q <= '0;
    end else begin
      state_q <= state_d;
      beats_q <= beats_d;
    end
  end

  avs_read_credit_counter #(
    .C_MAX_PENDING_BEATS(C_MAX_PENDING_BEATS),
    .C_LEN_WIDTH        (BW)
  ) u_credit (
    .clk      (ACLK),
    .srst     (ARESET),
    .burst_len(eff_burst),
    .ar_fire  (ar_fire),
    .rvalid   (rvalid),
    .credit_ok(credit_ok),
    .pending  (pending_beats)
  );

endmodule

// File: doc/avalon_burst_slave_interface.md
Name: avalon_burst_slave_interface

Overview:
- Parametrised successor to the single-beat Avalon-MM slave bridge.
- Converts Avalon-MM slave bursts (write and pipelined read, with burstcount) into the user bus: AW/W/AR/R channels with burst length and wlast/rlast.
- Bounds outstanding read beats with a credit counter so downstream read-return buffering never overflows.
- Sits between the Avalon interconnect (Qsys) and user logic / CoRAM control registers.

Parameters:
- C_AVS_ADDR_WIDTH, 32, address width (byte address, passed through unchanged).
- C_AVS_DATA_WIDTH, 32, data width; multiple of 8.
- C_AVS_BURST_WIDTH, 4, burstcount width; maximum legal burst is 2^(C_AVS_BURST_WIDTH-1) beats.
- C_MAX_PENDING_BEATS, 16, outstanding read beat limit; must be >= maximum burst.

Ports:
- ACLK  in  1  clock, all logic on the rising edge.
- ARESET  in  1  synchronous active-high reset.
- awaddr  out  ADDR  write burst start address.
- awlen  out  BURST  beats-1 of the write burst.
- awvalid  out  1  write address valid.
- awready  in  1  write address ready.
- wdata  out  DATA  write beat data.
- wstrb  out  DATA/8  write beat byte strobes.
- wlast  out  1  final beat of the write burst.
- wvalid  out  1  write beat valid.
- wready  in  1  write beat ready.
- araddr  out  ADDR  read burst start address.
- arlen  out  BURST  beats-1 of the read burst.
- arvalid  out  1  read address valid.
- arready  in  1  read address ready.
- rdata  in  DATA  read beat data.
- rlast  in  1  final read beat; informational only.
- rvalid  in  1  read beat valid.
- rready  out  1  constant 1.
- avs_address  in  ADDR  Avalon address.
- avs_burstcount  in  BURST  Avalon burst length; value 0 is treated as 1.
- avs_byteenable  in  DATA/8  Avalon byte enables.
- avs_read  in  1  Avalon read request.
- avs_write  in  1  Avalon write request / write beat.
- avs_writedata  in  DATA  Avalon write data.
- avs_waitrequest  out  1  Avalon stall.
- avs_readdata  out  DATA  equals rdata.
- avs_readdatavalid  out  1  equals rvalid.

Behaviour:
- No internal reset synchroniser; ARESET is used directly.
- While ARESET=1: awvalid=wvalid=arvalid=0, avs_waitrequest=1, FSM=W_IDLE, beat counter=0, pending=0.
- Write FSM states:
  - W_IDLE: awvalid = avs_write; awaddr = avs_address; awlen = max(burstcount,1)-1.
    - avs_waitrequest=1 (first beat not yet accepted).
    - On awvalid&&awready: load beat counter = max(burstcount,1); go to W_DATA.
  - W_DATA: wvalid = avs_write; wdata/wstrb = avs_writedata/byteenable; wlast = (counter==1); avs_waitrequest = !wready.
    - Beat accepted on avs_write&&wready; counter decrements.
    - Last beat returns to W_IDLE.
    - avs_write=0 mid-burst: hold state, wvalid=0.
- Write latency: AW in cycle N, first beat accepted at the earliest in cycle N+1; one bubble per burst.
- Read path, active only in W_IDLE with avs_write=0:
  - arvalid = avs_read && (pending + max(burstcount,1) <= C_MAX_PENDING_BEATS).
  - araddr = avs_address; arlen = max(burstcount,1)-1.
  - avs_waitrequest = !(arvalid&&arready).
- Pending read counter:
  - +max(burstcount,1) on AR handshake; -1 on each rvalid.
  - Simultaneous increment and decrement applies the net change in one cycle.
  - Decrement saturates at 0; rvalid arriving after a mid-flight reset is forwarded but not counted.
- Arbitration:
  - avs_read and avs_write both high in W_IDLE (illegal Avalon, tolerated): write wins, arvalid=0.
  - Read requested in W_DATA: avs_waitrequest=1, arvalid=0.
- Pending counter width: clog2(C_MAX_PENDING_BEATS+1).
- Reset mid-burst: FSM aborts to W_IDLE. The user bus sees an incomplete burst; this is acceptable only on a global reset.

Decomposition:
- Package avalon_bridge_pkg:
  - write FSM state encoding (W_IDLE, W_DATA);
  - function effective_burst(burstcount), mapping 0 to 1;
  - clog2 helper.
- Sub-module avs_read_credit_counter: pending counter, credit check, saturating decrement; reused by future master-side bridges.

Test Plan:
- Single write, burstcount=1, addr=0x40, data=0xDEADBEEF, awready=wready=1 -> awlen=0; wlast=1 in the following cycle; waitrequest low exactly one cycle.
- Write burst of 4, wready low for 2 cycles on beat 2 -> awlen=3; waitrequest high during the stall; wlast only on beat 4; 4 beats delivered in order.
- Read bursts of 8 with C_MAX_PENDING_BEATS=16, rvalid held off -> two ARs accepted; third stalls with waitrequest=1 until 8 rvalid beats return, then issues.
- Simultaneous AR handshake (burst 4) and rvalid with pending=5 -> pending=8 next cycle.
- burstcount=0 read -> arlen=0; pending increments by 1.
- ARESET asserted during beat 2 of a 4-beat write -> next cycle FSM=W_IDLE, wvalid=0, waitrequest=1; a new burst after release behaves normally.
